// File: rtl/riscv_pkg.sv
// RV32I decode types, control enums and mask/match patterns.
// Shared by the decode stage and its combinational decoder.
package riscv_pkg;

  typedef enum logic [2:0] {
    ALU_X, ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR, ALU_XOR, ALU_SLT, ALU_COPY2
  } exec_fun_e;

  typedef enum logic [1:0] {
    OP1_X, OP1_RS1, OP1_PC
  } op1_sel_e;

  typedef enum logic [2:0] {
    OP2_X, OP2_RS2, OP2_IMI, OP2_IMS, OP2_IMU
  } op2_sel_e;

  typedef enum logic [1:0] {
    WB_X, WB_ALU, WB_MEM, WB_PC4
  } wb_sel_e;

  typedef enum logic {RF_X, RF_WRITE} rf_wen_e;
  typedef enum logic {MEM_X, MEM_WRITE} mem_wen_e;

  typedef enum logic [1:0] {
    PC_X, PC_PLUS4, PC_BRANCH, PC_JUMP
  } pc_sel_e;

  typedef struct packed {
    exec_fun_e   exec_fun;
    op1_sel_e    op1_sel;
    op2_sel_e    op2_sel;
    wb_sel_e     wb_sel;
    rf_wen_e     rf_wen;
    mem_wen_e    mem_wen;
    pc_sel_e     pc_sel;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        illegal;
  } dec_t;

  localparam logic [31:0] MASK_R = 32'hFE00707F;
  localparam logic [31:0] MASK_I = 32'h0000707F;
  localparam logic [31:0] MASK_U = 32'h0000007F;

  localparam logic [31:0] M_ADD   = 32'h00000033;
  localparam logic [31:0] M_SUB   = 32'h40000033;
  localparam logic [31:0] M_AND   = 32'h00007033;
  localparam logic [31:0] M_OR    = 32'h00006033;
  localparam logic [31:0] M_XOR   = 32'h00004033;
  localparam logic [31:0] M_SLT   = 32'h00002033;
  localparam logic [31:0] M_ADDI  = 32'h00000013;
  localparam logic [31:0] M_ANDI  = 32'h00007013;
  localparam logic [31:0] M_ORI   = 32'h00006013;
  localparam logic [31:0] M_XORI  = 32'h00004013;
  localparam logic [31:0] M_LW    = 32'h00002003;
  localparam logic [31:0] M_SW    = 32'h00002023;
  localparam logic [31:0] M_BEQ   = 32'h00000063;
  localparam logic [31:0] M_BNE   = 32'h00001063;
  localparam logic [31:0] M_JALR  = 32'h00000067;
  localparam logic [31:0] M_JAL   = 32'h0000006F;
  localparam logic [31:0] M_LUI   = 32'h00000037;
  localparam logic [31:0] M_AUIPC = 32'h00000017;

  function automatic logic hit(
    input logic [31:0] i,
    input logic [31:0] m,
    input logic [31:0] v
  );
    return (i & m) == v;
  endfunction

  function automatic dec_t mk(
    input exec_fun_e   f,
    input op1_sel_e    a,
    input op2_sel_e    b,
    input wb_sel_e     w,
    input rf_wen_e     r,
    input mem_wen_e    m,
    input pc_sel_e     p,
    input logic [31:0] imm
  );
    dec_t d;
    d          = '0;
    d.exec_fun = f;
    d.op1_sel  = a;
    d.op2_sel  = b;
    d.wb_sel   = w;
    d.rf_wen   = r;
    d.mem_wen  = m;
    d.pc_sel   = p;
    d.imm      = imm;
    return d;
  endfunction

endpackage

// File: rtl/riscv_decode_comb.sv
// Pure combinational RV32I subset decoder.
// Unmatched words decode to all-_X controls with the illegal flag.
module riscv_decode_comb
  import riscv_pkg::*;
(
  input  logic [31:0] inst_i,
  output dec_t        dec_o
);

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] w;
  dec_t        d;

  assign w     = inst_i;
  assign imm_i = {{20{w[31]}}, w[31:20]};
  assign imm_s = {{20{w[31]}}, w[31:25], w[11:7]};
  assign imm_b = {{19{w[31]}}, w[31], w[7],
                  w[30:25], w[11:8], 1'b0};
  assign imm_u = {w[31:12], 12'h000};
  assign imm_j = {{11{w[31]}}, w[31], w[19:12],
                  w[20], w[30:21], 1'b0};

  always_comb begin
    d         = '0;
    d.pc_sel  = PC_PLUS4;
    d.illegal = 1'b1;
    unique case (1'b1)
      hit(w, MASK_R, M_ADD):
        d = mk(ALU_ADD, OP1_RS1, OP2_RS2, WB_ALU,
               RF_WRITE, MEM_X, PC_PLUS4, '0);
      hit(w, MASK_R, M_SUB):
        d = mk(ALU_SUB, OP1_RS1, OP2_RS2, WB_ALU,
               RF_WRITE, MEM_X, PC_PLUS4, '0);
      hit(w, MASK_R, M_AND):
        d = mk(ALU_AND, OP1_RS1, OP2_RS2, WB_ALU,
               RF_WRITE, MEM_X, PC_PLUS4, '0);
      hit(w, MASK_R, M_OR):
        d = mk(ALU_OR, OP1_RS1, OP2_RS2, WB_ALU,
               RF_WRITE, MEM_X, PC_PLUS4, '0);
      hit(w, MASK_R, M_XOR):
        d = mk(ALU_XOR, OP1_RS1, OP2_RS2, WB_ALU,
               RF_WRITE, MEM_X, PC_PLUS4, '0);
      hit(w, MASK_R, M_SLT):
        d = mk(ALU_SLT, OP1_RS1, OP2_RS2, WB_ALU,
               RF_WRITE, MEM_X, PC_PLUS4, '0);
      hit(w, MASK_I, M_ADDI):
        d = mk(ALU_ADD, OP1_RS1, OP2_IMI, WB_ALU,
               RF_WRITE, MEM_X, PC_PLUS4, imm_i);
      hit(w, MASK_I, M_ANDI):
        d = mk(ALU_AND, OP1_RS1, OP2_IMI, WB_ALU,
               RF_WRITE, MEM_X, PC_PLUS4, imm_i);
      hit(w, MASK_I, M_ORI):
        d = mk(ALU_OR, OP1_RS1, OP2_IMI, WB_ALU,
               RF_WRITE, MEM_X, PC_PLUS4, imm_i);
      hit(w, MASK_I, M_XORI):
        d = mk(ALU_XOR, OP1_RS1, OP2_IMI, WB_ALU,
               RF_WRITE, MEM_X, PC_PLUS4, imm_i);
      hit(w, MASK_I, M_LW):
        d = mk(ALU_ADD, OP1_RS1, OP2_IMI, WB_MEM,
               RF_WRITE, MEM_X, PC_PLUS4, imm_i);
      hit(w, MASK_I, M_SW):
        d = mk(ALU_ADD, OP1_RS1, OP2_IMS, WB_X,
               RF_X, MEM_WRITE, PC_PLUS4, imm_s);
      hit(w, MASK_I, M_BEQ):
        d = mk(ALU_SUB, OP1_RS1, OP2_RS2, WB_X,
               RF_X, MEM_X, PC_BRANCH, imm_b);
      hit(w, MASK_I, M_BNE):
        d = mk(ALU_SUB, OP1_RS1, OP2_RS2, WB_X,
               RF_X, MEM_X, PC_BRANCH, imm_b);
      hit(w, MASK_I, M_JALR):
        d = mk(ALU_ADD, OP1_RS1, OP2_IMI, WB_PC4,
               RF_WRITE, MEM_X, PC_JUMP, imm_i);
      hit(w, MASK_U, M_JAL):
        d = mk(ALU_ADD, OP1_PC, OP2_X, WB_PC4,
               RF_WRITE, MEM_X, PC_JUMP, imm_j);
      hit(w, MASK_U, M_LUI):
        d = mk(ALU_COPY2, OP1_X, OP2_IMU, WB_ALU,
               RF_WRITE, MEM_X, PC_PLUS4, imm_u);
      hit(w, MASK_U, M_AUIPC):
        d = mk(ALU_ADD, OP1_PC, OP2_IMU, WB_ALU,
               RF_WRITE, MEM_X, PC_PLUS4, imm_u);
      default: ;
    endcase
    d.rs1 = w[19:15];
    d.rs2 = w[24:20];
    d.rd  = w[11:7];
  end

  assign dec_o = d;

endmodule

// File: rtl/riscv_decode_stage.sv
// Registered decode stage: output register plus optional skid entry,
// flush, and a saturating illegal-instruction counter.
module riscv_decode_stage
  import riscv_pkg::*;
#(
  parameter int SKID_EN = 1,
  parameter int PC_W    = 32,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output exec_fun_e        out_exec_fun,
  output op1_sel_e         out_op1_sel,
  output op2_sel_e         out_op2_sel,
  output wb_sel_e          out_wb_sel,
  output rf_wen_e          out_rf_wen,
  output mem_wen_e         out_mem_wen,
  output pc_sel_e          out_pc_sel,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [31:0]      out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  dec_t             dec_in;
  dec_t             out_q, out_d, skid_q, skid_d;
  logic [PC_W-1:0]  opc_q, opc_d, spc_q, spc_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_full_q, skid_full_d;
  logic             ready_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, slot_free;

  riscv_decode_comb u_dec (
    .inst_i (in_inst),
    .dec_o  (dec_in)
  );

  // ready_q is low in reset and mirrors !skid_full afterwards
  assign in_ready  = (SKID_EN != 0) ? ready_q
                   : ready_q && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign slot_free = !out_valid_q || out_ready;

  always_comb begin
    out_d       = out_q;
    opc_d       = opc_q;
    skid_d      = skid_q;
    spc_d       = spc_q;
    out_valid_d = out_valid_q;
    skid_full_d = skid_full_q;
    cnt_d       = cnt_q;
    if (flush) begin
      out_valid_d = 1'b0;
      skid_full_d = 1'b0;
    end else begin
      if (accept && dec_in.illegal && cnt_q != '1)
        cnt_d = cnt_q + 1'b1;
      if (slot_free) begin
        if (skid_full_q) begin
          out_d       = skid_q;
          opc_d       = spc_q;
          out_valid_d = 1'b1;
          skid_full_d = 1'b0;
        end else begin
          out_valid_d = accept;
          if (accept) begin
            out_d = dec_in;
            opc_d = in_pc;
          end
        end
      end else if (accept && SKID_EN != 0) begin
        skid_d      = dec_in;
        spc_d       = in_pc;
        skid_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q       <= '0;
      opc_q       <= '0;
      skid_q      <= '0;
      spc_q       <= '0;
      out_valid_q <= 1'b0;
      skid_full_q <= 1'b0;
      ready_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_q       <= out_d;
      opc_q       <= opc_d;
      skid_q      <= skid_d;
      spc_q       <= spc_d;
      out_valid_q <= out_valid_d;
      skid_full_q <= skid_full_d;
      ready_q     <= !skid_full_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_pc       = opc_q;
  assign out_exec_fun = out_q.exec_fun;
  assign out_op1_sel  = out_q.op1_sel;
  assign out_op2_sel  = out_q.op2_sel;
  assign out_wb_sel   = out_q.wb_sel;
  assign out_rf_wen   = out_q.rf_wen;
  assign out_mem_wen  = out_q.mem_wen;
  assign out_pc_sel   = out_q.pc_sel;
  assign out_rs1      = out_q.rs1;
  assign out_rs2      = out_q.rs2;
  assign out_rd       = out_q.rd;
  assign out_imm      = out_q.imm;
  assign out_illegal  = out_q.illegal;
  assign illegal_cnt  = cnt_q;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Directed bench for riscv_decode_stage: a skid instance with
// default widths and a no-skid instance with a 2-bit counter.
module tb_riscv_decode_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  exec_fun_e   out_exec_fun;
  op1_sel_e    out_op1_sel;
  op2_sel_e    out_op2_sel;
  wb_sel_e     out_wb_sel;
  rf_wen_e     out_rf_wen;
  mem_wen_e    out_mem_wen;
  pc_sel_e     out_pc_sel;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_imm;
  logic        out_illegal;
  logic [15:0] illegal_cnt;

  logic        in_valid2 = 1'b0;
  logic        in_ready2;
  logic [31:0] in_inst2 = '0;
  logic        out_valid2;
  logic        out_ready2 = 1'b1;
  logic [31:0] out_pc2;
  exec_fun_e   exec2;
  op1_sel_e    op1_2;
  op2_sel_e    op2_2;
  wb_sel_e     wb2;
  rf_wen_e     rf2;
  mem_wen_e    mem2;
  pc_sel_e     pcs2;
  logic [4:0]  rs1_2, rs2_2, rd2;
  logic [31:0] imm2;
  logic        ill2;
  logic [1:0]  cnt2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  riscv_decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_exec_fun(out_exec_fun),
    .out_op1_sel(out_op1_sel), .out_op2_sel(out_op2_sel),
    .out_wb_sel(out_wb_sel), .out_rf_wen(out_rf_wen),
    .out_mem_wen(out_mem_wen), .out_pc_sel(out_pc_sel),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_illegal(out_illegal),
    .illegal_cnt(illegal_cnt)
  );

  riscv_decode_stage #(.SKID_EN(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .in_inst(in_inst2), .in_pc(32'h0),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_pc(out_pc2), .out_exec_fun(exec2),
    .out_op1_sel(op1_2), .out_op2_sel(op2_2),
    .out_wb_sel(wb2), .out_rf_wen(rf2),
    .out_mem_wen(mem2), .out_pc_sel(pcs2),
    .out_rs1(rs1_2), .out_rs2(rs2_2), .out_rd(rd2),
    .out_imm(imm2), .out_illegal(ill2),
    .illegal_cnt(cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL rst_valid got %0b want 0", out_valid); end
    n_chk++; if (in_ready !== 1'b0) begin n_fail++;
      $display("FAIL rst_ready got %0b want 0", in_ready); end
    n_chk++; if (illegal_cnt !== 16'd0) begin n_fail++;
      $display("FAIL rst_cnt got %0d want 0", illegal_cnt); end
    n_chk++; if (out_illegal !== 1'b0) begin n_fail++;
      $display("FAIL rst_illegal got %0b want 0", out_illegal); end
    n_chk++; if (out_exec_fun !== ALU_X || out_pc_sel !== PC_X
                 || out_imm !== 32'd0) begin n_fail++;
      $display("FAIL rst_fields got %0d/%0d/%h want 0/0/0",
               out_exec_fun, out_pc_sel, out_imm); end
    rst = 1'b0;
    tick();
    n_chk++; if (in_ready !== 1'b1) begin n_fail++;
      $display("FAIL rel_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_add();
    in_valid = 1'b1; in_inst = 32'h002081B3; in_pc = 32'h100;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin
      n_fail++; $display("FAIL add_valid got %0b/%h want 1/100",
                         out_valid, out_pc); end
    n_chk++; if (out_exec_fun !== ALU_ADD || out_op2_sel !== OP2_RS2
                 || out_rf_wen !== RF_WRITE) begin n_fail++;
      $display("FAIL add_ctl got %0d/%0d/%0d want %0d/%0d/%0d",
               out_exec_fun, out_op2_sel, out_rf_wen,
               ALU_ADD, OP2_RS2, RF_WRITE); end
    n_chk++; if (out_rs1 !== 5'd1 || out_rs2 !== 5'd2
                 || out_rd !== 5'd3) begin n_fail++;
      $display("FAIL add_regs got %0d/%0d/%0d want 1/2/3",
               out_rs1, out_rs2, out_rd); end
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL add_drain got %0b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_inst = 32'h0020A423; in_pc = 32'h104;
    tick();
    in_inst = 32'h00208863; in_pc = 32'h108;
    n_chk++; if (out_mem_wen !== MEM_WRITE || out_op2_sel !== OP2_IMS
                 || out_imm !== 32'd8) begin n_fail++;
      $display("FAIL sw got %0d/%0d/%0d want %0d/%0d/8",
               out_mem_wen, out_op2_sel, out_imm,
               MEM_WRITE, OP2_IMS); end
    tick();
    in_valid = 1'b0;
    n_chk++; if (out_pc_sel !== PC_BRANCH || out_imm !== 32'd16
                 || out_pc !== 32'h108 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL beq got %0d/%0d/%h want %0d/16/108",
                         out_pc_sel, out_imm, out_pc, PC_BRANCH); end
    tick();
  endtask

  task automatic test_formats();
    logic [31:0] iv [5];
    logic [31:0] ei [5];
    op1_sel_e    e1 [5];
    op2_sel_e    e2 [5];
    wb_sel_e     ew [5];
    pc_sel_e     ep [5];
    iv[0] = 32'hFFF00093; ei[0] = 32'hFFFFFFFF;
    e1[0] = OP1_RS1; e2[0] = OP2_IMI; ew[0] = WB_ALU; ep[0] = PC_PLUS4;
    iv[1] = 32'h0040A183; ei[1] = 32'h4;
    e1[1] = OP1_RS1; e2[1] = OP2_IMI; ew[1] = WB_MEM; ep[1] = PC_PLUS4;
    iv[2] = 32'h12345037; ei[2] = 32'h12345000;
    e1[2] = OP1_X;   e2[2] = OP2_IMU; ew[2] = WB_ALU; ep[2] = PC_PLUS4;
    iv[3] = 32'h00001017; ei[3] = 32'h1000;
    e1[3] = OP1_PC;  e2[3] = OP2_IMU; ew[3] = WB_ALU; ep[3] = PC_PLUS4;
    iv[4] = 32'h0080006F; ei[4] = 32'h8;
    e1[4] = OP1_PC;  e2[4] = OP2_X;   ew[4] = WB_PC4; ep[4] = PC_JUMP;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_inst = iv[i]; in_pc = 32'h300 + 4 * i;
      tick();
      n_chk++;
      if (out_imm !== ei[i] || out_op1_sel !== e1[i]
          || out_op2_sel !== e2[i] || out_wb_sel !== ew[i]
          || out_pc_sel !== ep[i] || out_illegal !== 1'b0) begin
        n_fail++;
        $display("FAIL fmt%0d got %h/%0d/%0d/%0d/%0d want %h/%0d/%0d/%0d/%0d",
                 i, out_imm, out_op1_sel, out_op2_sel, out_wb_sel,
                 out_pc_sel, ei[i], e1[i], e2[i], ew[i], ep[i]);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    for (int i = 0; i < 5; i++) begin
      in_valid = (i < 3); in_inst = 32'hFFFFFFFF; in_pc = 32'h400;
      in_valid2 = 1'b1; in_inst2 = 32'hFFFFFFFF;
      tick();
      if (i < 3) begin
        n_chk++;
        if (out_valid !== 1'b1 || out_illegal !== 1'b1
            || out_exec_fun !== ALU_X || out_pc_sel !== PC_PLUS4
            || out_imm !== 32'd0) begin
          n_fail++;
          $display("FAIL ill%0d got v%0b i%0b f%0d p%0d m%h want 1/1/0/%0d/0",
                   i, out_valid, out_illegal, out_exec_fun,
                   out_pc_sel, out_imm, PC_PLUS4);
        end
      end
    end
    in_valid = 1'b0; in_valid2 = 1'b0;
    n_chk++; if (illegal_cnt !== 16'd3) begin n_fail++;
      $display("FAIL ill_cnt got %0d want 3", illegal_cnt); end
    n_chk++; if (cnt2 !== 2'd3) begin n_fail++;
      $display("FAIL ill_sat got %0d want 3", cnt2); end
    out_ready2 = 1'b0;
    #1;
    n_chk++; if (in_ready2 !== 1'b0) begin n_fail++;
      $display("FAIL noskid_stall got %0b want 0", in_ready2); end
    out_ready2 = 1'b1;
    #1;
    n_chk++; if (in_ready2 !== 1'b1) begin n_fail++;
      $display("FAIL noskid_go got %0b want 1", in_ready2); end
    tick();
  endtask

  task automatic test_skid_stream();
    in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 32'h200;
    out_ready = 1'b0;
    tick();
    n_chk++; if (out_pc !== 32'h200 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL skid_a got %h/%0b want 200/1",
                         out_pc, in_ready); end
    in_inst = 32'h00200093; in_pc = 32'h204;
    tick();
    n_chk++; if (out_pc !== 32'h200 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL skid_b got %h/%0b want 200/0",
                         out_pc, in_ready); end
    in_inst = 32'h00300093; in_pc = 32'h208;
    tick();
    n_chk++; if (out_pc !== 32'h200 || out_imm !== 32'd1
                 || in_ready !== 1'b0) begin n_fail++;
      $display("FAIL skid_hold got %h/%0d/%0b want 200/1/0",
               out_pc, out_imm, in_ready); end
    out_ready = 1'b1;
    tick();
    n_chk++; if (out_pc !== 32'h204 || out_imm !== 32'd2
                 || in_ready !== 1'b1) begin n_fail++;
      $display("FAIL skid_out_b got %h/%0d/%0b want 204/2/1",
               out_pc, out_imm, in_ready); end
    tick();
    in_valid = 1'b0;
    n_chk++; if (out_pc !== 32'h208 || out_imm !== 32'd3
                 || out_valid !== 1'b1) begin n_fail++;
      $display("FAIL skid_out_c got %h/%0d/%0b want 208/3/1",
               out_pc, out_imm, out_valid); end
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL skid_end got %0b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 32'h500;
    tick();
    in_pc = 32'h504;
    tick();
    in_inst = 32'hFFFFFFFF; in_pc = 32'h508;
    flush = 1'b1;
    tick();
    n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1
                 || illegal_cnt !== 16'd3) begin n_fail++;
      $display("FAIL flush_full got %0b/%0b/%0d want 0/1/3",
               out_valid, in_ready, illegal_cnt); end
    tick();
    n_chk++; if (out_valid !== 1'b0 || illegal_cnt !== 16'd3) begin
      n_fail++; $display("FAIL flush_in got %0b/%0d want 0/3",
                         out_valid, illegal_cnt); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    n_chk++; if (out_valid !== 1'b0) begin n_fail++;
      $display("FAIL flush_after got %0b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h002081B3; in_pc = 32'h600;
    tick();
    in_pc = 32'h604;
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b0
                 || illegal_cnt !== 16'd0 || out_pc !== 32'd0
                 || out_exec_fun !== ALU_X) begin n_fail++;
      $display("FAIL arst got %0b/%0b/%0d/%h/%0d want 0/0/0/0/0",
               out_valid, in_ready, illegal_cnt, out_pc, out_exec_fun);
    end
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_fail++; $display("FAIL stale%0d got %0b/%0b want 0/1",
                           i, out_valid, in_ready); end
    end
    in_valid = 1'b1; in_inst = 32'h002081B3; in_pc = 32'h700;
    tick();
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'h700
                 || out_rd !== 5'd3) begin n_fail++;
      $display("FAIL post_rst got %0b/%h/%0d want 1/700/3",
               out_valid, out_pc, out_rd); end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_formats();
    test_illegal();
    test_skid_stream();
    test_flush();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/riscv_decode_stage.md
RISCV_DECODE_STAGE -- requirements
Module: riscv_decode_stage

Interface
REQ-001 SHALL have parameter SKID_EN, default 1, meaning 1 = two-entry skid buffer and 0 = single pipeline register.
REQ-002 SHALL have parameter PC_W, default 32, meaning width of the PC sideband.
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of the illegal-instruction counter.
REQ-004 SHALL have these ports, one per line:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- flush  input  1  discard all held and incoming instructions.
- in_valid / in_ready  input / output  1 / 1  upstream handshake.
- in_inst  input  32  instruction word.
- in_pc  input  PC_W  PC of in_inst.
- out_valid / out_ready  output / input  1 / 1  downstream handshake.
- out_pc  output  PC_W  PC of the held instruction.
- out_exec_fun, out_op1_sel, out_op2_sel, out_wb_sel, out_rf_wen, out_mem_wen, out_pc_sel  output  package enums  decoded control.
- out_rs1, out_rs2, out_rd  output  5 each  register indices.
- out_imm  output  32  sign-extended immediate, per format.
- out_illegal  output  1  held instruction matched no pattern.
- illegal_cnt  output  CNT_W  saturating count of illegal instructions accepted.

Function
REQ-005 SHALL decode ADD, SUB, AND, OR, XOR, SLT, ADDI, ANDI, ORI, XORI, LW, SW, BEQ, BNE, JAL, JALR, LUI and AUIPC by mask/match.
REQ-006 SHALL give loads and I-ALU ops op2 = I-imm; SW op2 = S-imm; branches pc_sel = PC_BRANCH with B-imm; JAL/JALR pc_sel = PC_JUMP, wb_sel = WB_PC4; LUI/AUIPC U-imm; AUIPC op1 = OP1_PC; all others pc_sel = PC_PLUS4.
REQ-007 SHALL, for an unmatched word, output ALU_X, OP1_X, OP2_X, WB_X, RF_X, MEM_X, PC_PLUS4, imm 0 and out_illegal = 1, still delivered with out_valid = 1.
REQ-008 SHALL accept an instruction on a rising edge when in_valid && in_ready, and present it registered on the outputs from the next cycle (latency 1).
REQ-009 SHALL keep all out_* fields stable while out_valid && !out_ready.
REQ-010 SHALL, when SKID_EN = 1, drive in_ready = !skid_full from a register, so in_ready has no combinational path from out_ready.
REQ-011 SHALL, when SKID_EN = 1, sustain one instruction per cycle while out_ready = 1.
REQ-012 SHALL, when SKID_EN = 1, handle a stall (output occupied, out_ready low) during an accept by loading the incoming instruction into the skid and setting skid_full.
REQ-013 SHALL, when SKID_EN = 1, move the skid entry to the output on the next cycle with out_ready = 1, in program order.
REQ-014 SHALL, when SKID_EN = 0, drive in_ready = !out_valid || out_ready combinationally.
REQ-015 SHALL, on flush = 1 at an edge, clear out_valid and skid_full and drop any same-cycle input; flush SHALL override accept and transfer.
REQ-016 SHALL increment illegal_cnt by 1 per accepted illegal instruction that is not flushed in the same cycle, saturating at all-ones.

Reset
REQ-017 SHALL, while rst = 1, asynchronously force out_valid = 0, skid_full = 0, illegal_cnt = 0, out_illegal = 0, all enums to their _X values and all other fields to 0.
REQ-018 SHALL hold in_ready = 0 while rst = 1, and set in_ready = 1 on the first cycle after release.
REQ-019 SHALL discard any in-flight instruction when reset is asserted mid-stall; it SHALL NOT reappear after release.

Structure
REQ-020 SHALL place the EXEC_FUN, OP1_SEL, OP2_SEL, WB_SEL, RF_WEN, MEM_WEN and PC_SEL enums (including new members ALU_SUB/AND/OR/XOR/SLT, OP1_PC, OP2_IMU, WB_PC4, PC_BRANCH, PC_JUMP) and all mask/match constants in the shared package riscv_pkg.
REQ-021 SHALL contain the pure combinational decode in one sub-module, riscv_decode_comb, instantiated once on the input path; riscv_decode_stage holds only registers and handshake logic.

Verification
REQ-022 SHALL cover: 0x002081B3 (ADD x3,x1,x2), out_ready = 1 -> next cycle ALU_ADD, OP2_RS2, RF_WRITE, rs1 = 1, rs2 = 2, rd = 3.
REQ-023 SHALL cover: 0x0020A423 (SW x2,8(x1)) -> MEM_WRITE, OP2_IMS, imm = 8; then 0x00208863 (BEQ x1,x2,+16) -> PC_BRANCH, imm = 16.
REQ-024 SHALL cover: 0xFFFFFFFF accepted three times -> out_illegal = 1 each time and illegal_cnt = 3; with CNT_W = 2 and five accepts, illegal_cnt saturates at 3.
REQ-025 SHALL cover: SKID_EN = 1 streaming A, B, C with out_ready low for 2 cycles -> in_ready drops after B is accepted, and outputs appear in order A, B, C with no loss or duplication.
REQ-026 SHALL cover: flush asserted with output and skid both full and in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, and illegal_cnt unchanged.
REQ-027 SHALL cover: rst pulsed mid-stall -> outputs reset immediately without waiting for a clock edge, and no stale instruction appears after release.
